// File: rtl/id_pkg.sv
// Shared decode constants and the instruction-class helper for the decode queue stage.
package id_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_COP1  = 6'h11;

  typedef enum logic [1:0] {
    ITYPE_R    = 2'b00,
    ITYPE_I    = 2'b01,
    ITYPE_J    = 2'b10,
    ITYPE_COP1 = 2'b11
  } i_type_e;

  function automatic i_type_e classify(input logic [5:0] op);
    case (op)
      OP_RTYPE:     classify = ITYPE_R;
      OP_J, OP_JAL: classify = ITYPE_J;
      OP_COP1:      classify = ITYPE_COP1;
      default:      classify = ITYPE_I;
    endcase
  endfunction

endpackage

// File: rtl/id_fifo.sv
// Circular instruction queue: power-of-two depth, head presented combinationally,
// flush and reset return it to empty with both pointers at zero.
module id_fifo
  import id_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             full_s;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full_s    = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign push_ok_s = push && !full_s && !flush;
  assign pop_ok_s  = pop && !empty && !flush;
  assign rdata     = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are meaningless outside the occupied window, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= wdata;
  end

endmodule

// File: rtl/id_queue_stage.sv
// Instruction decode stage: queues fetched {instr, pc} pairs and decodes the head
// into a registered output slot with valid/ready handshake, halt freeze and flush.
module id_queue_stage
  import id_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   if_valid,
  input  logic [31:0]            if_instr,
  input  logic [PC_W-1:0]        if_pc,
  output logic                   if_ready,
  input  logic                   halt_fetch,
  input  logic                   halt_control,
  input  logic                   flush,
  input  logic                   ex_ready,
  output logic                   id_valid,
  output logic [5:0]             opcode,
  output logic [4:0]             format,
  output logic [5:0]             funct,
  output logic [4:0]             rs,
  output logic [4:0]             rt,
  output logic [4:0]             rd,
  output logic [4:0]             sa,
  output logic [15:0]            imm,
  output logic [25:0]            offset,
  output logic [4:0]             base,
  output logic [4:0]             bltz,
  output logic [1:0]             i_type,
  output logic [PC_W-1:0]        pc_out,
  output logic                   halt_out,
  output logic [4:0]             rs_reg,
  output logic [4:0]             rt_reg,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int FW = 32 + PC_W;

  logic            push_s;
  logic            pop_s;
  logic            empty_s;
  logic [FW-1:0]   head_s;
  logic [31:0]     head_instr_s;
  logic [PC_W-1:0] head_pc_s;

  assign if_ready     = (count < CW'(DEPTH));
  assign push_s       = if_valid && if_ready && !halt_fetch && !flush;
  assign pop_s        = !empty_s && !halt_control && !flush && (!id_valid || ex_ready);
  assign head_instr_s = head_s[FW-1:PC_W];
  assign head_pc_s    = head_s[PC_W-1:0];

  id_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (push_s),
    .pop   (pop_s),
    .wdata ({if_instr, if_pc}),
    .rdata (head_s),
    .count (count),
    .empty (empty_s)
  );

  // Register-file read addresses follow the queue head, forced to zero when empty.
  always_comb begin
    rs_reg = 5'd0;
    rt_reg = 5'd0;
    if (empty_s) begin
      rs_reg = 5'd0;
      rt_reg = 5'd0;
    end else begin
      rs_reg = head_instr_s[25:21];
      rt_reg = head_instr_s[20:16];
    end
  end

  // Decoded output slot: loads on pop, empties when consumed with nothing behind it,
  // otherwise holds (which covers both downstream stall and halt_control freeze).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_valid <= 1'b0;
      halt_out <= 1'b0;
      opcode   <= 6'd0;
      format   <= 5'd0;
      funct    <= 6'd0;
      rs       <= 5'd0;
      rt       <= 5'd0;
      rd       <= 5'd0;
      sa       <= 5'd0;
      imm      <= 16'd0;
      offset   <= 26'd0;
      base     <= 5'd0;
      bltz     <= 5'd0;
      i_type   <= 2'b00;
      pc_out   <= {PC_W{1'b0}};
    end else begin
      halt_out <= halt_control;
      if (flush) begin
        id_valid <= 1'b0;
      end else if (pop_s) begin
        id_valid <= 1'b1;
        opcode   <= head_instr_s[31:26];
        format   <= head_instr_s[25:21];
        rs       <= head_instr_s[25:21];
        base     <= head_instr_s[25:21];
        rt       <= head_instr_s[20:16];
        bltz     <= head_instr_s[20:16];
        rd       <= head_instr_s[15:11];
        sa       <= head_instr_s[10:6];
        funct    <= head_instr_s[5:0];
        imm      <= head_instr_s[15:0];
        offset   <= head_instr_s[25:0];
        i_type   <= classify(head_instr_s[31:26]);
        pc_out   <= head_pc_s;
      end else if (!halt_control && (!id_valid || ex_ready)) begin
        id_valid <= 1'b0;
      end else begin
        id_valid <= id_valid;
      end
    end
  end

endmodule

// File: tb/tb_id_queue_stage.sv
// Scoreboard bench for id_queue_stage: directed pushes enqueue expected decodes,
// a negedge monitor compares every instruction handed to the execute stage.
module tb_id_queue_stage;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;

  logic        clk;
  logic        reset;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;
  logic        halt_fetch;
  logic        halt_control;
  logic        flush;
  logic        ex_ready;
  logic        id_valid;
  logic [5:0]  opcode;
  logic [4:0]  format;
  logic [5:0]  funct;
  logic [4:0]  rs, rt, rd, sa, base, bltz;
  logic [15:0] imm;
  logic [25:0] offset;
  logic [1:0]  i_type;
  logic [31:0] pc_out;
  logic        halt_out;
  logic [4:0]  rs_reg, rt_reg;
  logic [2:0]  count;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [1:0]  ity;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  id_queue_stage #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_ready(if_ready), .halt_fetch(halt_fetch), .halt_control(halt_control), .flush(flush),
    .ex_ready(ex_ready), .id_valid(id_valid), .opcode(opcode), .format(format), .funct(funct),
    .rs(rs), .rt(rt), .rd(rd), .sa(sa), .imm(imm), .offset(offset), .base(base), .bltz(bltz),
    .i_type(i_type), .pc_out(pc_out), .halt_out(halt_out), .rs_reg(rs_reg), .rt_reg(rt_reg),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_push(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [1:0] ity, input bit accept);
    exp_t e;
    if_valid = 1'b1;
    if_instr = instr;
    if_pc    = pc;
    @(posedge clk);
    if (accept) begin
      e.instr = instr;
      e.pc    = pc;
      e.ity   = ity;
      sb.push_back(e);
    end
    #1;
    if_valid = 1'b0;
  endtask

  // Monitor: an instruction is consumed when presented valid, accepted, and not frozen or flushed.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && id_valid && ex_ready && !halt_control && !flush) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_output", {32'd0, pc_out}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("mon_opcode", {58'd0, opcode}, {58'd0, e.instr[31:26]});
        chk("mon_rs",     {59'd0, rs},     {59'd0, e.instr[25:21]});
        chk("mon_format", {59'd0, format}, {59'd0, e.instr[25:21]});
        chk("mon_base",   {59'd0, base},   {59'd0, e.instr[25:21]});
        chk("mon_rt",     {59'd0, rt},     {59'd0, e.instr[20:16]});
        chk("mon_bltz",   {59'd0, bltz},   {59'd0, e.instr[20:16]});
        chk("mon_rd",     {59'd0, rd},     {59'd0, e.instr[15:11]});
        chk("mon_sa",     {59'd0, sa},     {59'd0, e.instr[10:6]});
        chk("mon_funct",  {58'd0, funct},  {58'd0, e.instr[5:0]});
        chk("mon_imm",    {48'd0, imm},    {48'd0, e.instr[15:0]});
        chk("mon_offset", {38'd0, offset}, {38'd0, e.instr[25:0]});
        chk("mon_i_type", {62'd0, i_type}, {62'd0, e.ity});
        chk("mon_pc_out", {32'd0, pc_out}, {32'd0, e.pc});
      end
    end
  end

  initial begin
    reset = 1'b1; if_valid = 1'b0; if_instr = 32'd0; if_pc = 32'd0;
    halt_fetch = 1'b0; halt_control = 1'b0; flush = 1'b0; ex_ready = 1'b0;
    tick(2);
    chk("rst_count",    {61'd0, count},    64'd0);
    chk("rst_if_ready", {63'd0, if_ready}, 64'd1);
    chk("rst_id_valid", {63'd0, id_valid}, 64'd0);
    chk("rst_halt_out", {63'd0, halt_out}, 64'd0);
    chk("rst_opcode",   {58'd0, opcode},   64'd0);
    chk("rst_pc_out",   {32'd0, pc_out},   64'd0);
    reset = 1'b0;
    tick(1);

    // First instruction: queued at one edge, decoded at the next.
    do_push(32'h3c1c_0000, 32'h0001_0004, 2'b01, 1'b1);
    chk("lat_count_after_push", {61'd0, count},    64'd1);
    chk("lat_id_valid_early",   {63'd0, id_valid}, 64'd0);
    tick(1);
    chk("lat_id_valid", {63'd0, id_valid}, 64'd1);
    chk("lat_opcode",   {58'd0, opcode},   64'h0F);
    chk("lat_rt",       {59'd0, rt},       64'h1C);
    chk("lat_imm",      {48'd0, imm},      64'd0);
    chk("lat_i_type",   {62'd0, i_type},   64'd1);
    chk("lat_pc_out",   {32'd0, pc_out},   64'h0001_0004);
    chk("lat_count",    {61'd0, count},    64'd0);

    // Second instruction waits in the queue while downstream stalls.
    do_push(32'h279c_0000, 32'h0001_0008, 2'b01, 1'b1);
    chk("stall_count",  {61'd0, count},  64'd1);
    chk("stall_opcode", {58'd0, opcode}, 64'h0F);
    chk("stall_pc_out", {32'd0, pc_out}, 64'h0001_0004);
    chk("stall_rs_reg", {59'd0, rs_reg}, 64'h1C);
    chk("stall_rt_reg", {59'd0, rt_reg}, 64'h1C);

    // Fill to DEPTH, then one dropped push, then drain in order.
    do_push(32'h8c43_0004, 32'h0001_000c, 2'b01, 1'b1);
    do_push(32'h4602_0801, 32'h0001_0010, 2'b11, 1'b1);
    do_push(32'h0800_0040, 32'h0001_0014, 2'b10, 1'b1);
    chk("full_count",    {61'd0, count},    64'd4);
    chk("full_if_ready", {63'd0, if_ready}, 64'd0);
    do_push(32'hdead_beef, 32'h0001_0018, 2'b01, 1'b0);
    chk("drop_count",  {61'd0, count},  64'd4);
    chk("drop_pc_out", {32'd0, pc_out}, 64'h0001_0004);
    ex_ready = 1'b1;
    tick(8);
    chk("drain_count",    {61'd0, count},    64'd0);
    chk("drain_id_valid", {63'd0, id_valid}, 64'd0);
    chk("drain_sb_empty", {32'd0, 32'(sb.size())}, 64'd0);

    // R-type and JAL classification.
    do_push(32'h0000_0000, 32'h0001_0100, 2'b00, 1'b1);
    do_push(32'h0c00_0010, 32'h0001_0104, 2'b10, 1'b1);
    tick(4);

    // Fetch halt blocks pushes.
    halt_fetch = 1'b1;
    do_push(32'h2108_0001, 32'h0001_0180, 2'b01, 1'b0);
    chk("hf_count", {61'd0, count}, 64'd0);
    halt_fetch = 1'b0;
    tick(1);
    chk("hf_id_valid", {63'd0, id_valid}, 64'd0);

    // Three queued entries, then flush with a simultaneous push.
    ex_ready = 1'b0;
    do_push(32'h2108_0001, 32'h0001_0200, 2'b01, 1'b1);
    do_push(32'h2108_0002, 32'h0001_0204, 2'b01, 1'b1);
    do_push(32'h2108_0003, 32'h0001_0208, 2'b01, 1'b1);
    do_push(32'h2108_0004, 32'h0001_020c, 2'b01, 1'b1);
    chk("pre_flush_count", {61'd0, count}, 64'd3);
    flush = 1'b1; if_valid = 1'b1; if_instr = 32'h2108_0005; if_pc = 32'h0001_0210;
    @(posedge clk);
    sb.delete();
    #1;
    flush = 1'b0; if_valid = 1'b0;
    chk("flush_count",    {61'd0, count},    64'd0);
    chk("flush_id_valid", {63'd0, id_valid}, 64'd0);
    chk("flush_if_ready", {63'd0, if_ready}, 64'd1);
    tick(1);
    chk("flush_push_ignored", {61'd0, count}, 64'd0);

    // Control halt freezes the output slot for three cycles.
    do_push(32'h2108_0001, 32'h0001_0300, 2'b01, 1'b1);
    do_push(32'h0000_0020, 32'h0001_0304, 2'b00, 1'b1);
    do_push(32'h0c00_0100, 32'h0001_0308, 2'b10, 1'b1);
    halt_control = 1'b1; ex_ready = 1'b1;
    chk("halt_out_late", {63'd0, halt_out}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("halt_out",      {63'd0, halt_out}, 64'd1);
      chk("halt_id_valid", {63'd0, id_valid}, 64'd1);
      chk("halt_pc_out",   {32'd0, pc_out},   64'h0001_0300);
      chk("halt_count",    {61'd0, count},    64'd2);
    end
    halt_control = 1'b0;
    tick(1);
    chk("halt_out_clear", {63'd0, halt_out}, 64'd0);
    tick(4);

    // Asynchronous reset mid-stream.
    ex_ready = 1'b0;
    do_push(32'h3c1c_0000, 32'h0001_0400, 2'b01, 1'b1);
    do_push(32'h279c_0000, 32'h0001_0404, 2'b01, 1'b1);
    chk("pre_rst_id_valid", {63'd0, id_valid}, 64'd1);
    #2;
    reset = 1'b1;
    sb.delete();
    #1;
    chk("mid_rst_id_valid", {63'd0, id_valid}, 64'd0);
    chk("mid_rst_opcode",   {58'd0, opcode},   64'd0);
    chk("mid_rst_pc_out",   {32'd0, pc_out},   64'd0);
    chk("mid_rst_imm",      {48'd0, imm},      64'd0);
    chk("mid_rst_count",    {61'd0, count},    64'd0);
    chk("mid_rst_rs_reg",   {59'd0, rs_reg},   64'd0);
    chk("mid_rst_if_ready", {63'd0, if_ready}, 64'd1);
    tick(1);
    reset = 1'b0;
    ex_ready = 1'b1;
    do_push(32'h8c43_0004, 32'h0001_0500, 2'b01, 1'b1);
    chk("post_rst_count", {61'd0, count}, 64'd1);
    tick(4);
    chk("final_sb_empty", {32'd0, 32'(sb.size())}, 64'd0);
    chk("final_count",    {61'd0, count},          64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
